// File: rtl/rr_index_arbiter.sv
// rr_index_arbiter
//   Round-robin arbiter over N request lines. It produces a registered winner
//   index plus a valid flag, and the index feeds a downstream 4-to-16 one-hot
//   decoder. Fairness (rotating pointer), grant hold and the timeout live here,
//   so the decoder can stay purely combinational.
//
// Ports
//   CLK           clock; every state update happens on the rising edge
//   RESET         synchronous, active-high reset
//   req           request vector; bit k belongs to requester k
//   grant_ack     consumer is done with the current grant (ignored while idle)
//   grant_idx     index of the current winner
//   grant_valid   grant_idx is valid and is being held
//   timeout_pulse one-cycle pulse when a grant is force-released
module rr_index_arbiter #(
   parameter int N       = 16,
   parameter int W       = 4,
   parameter int TIMEOUT = 255,
   parameter int CW      = 8
) (
   input  logic         CLK,
   input  logic         RESET,
   input  logic [N-1:0] req,
   input  logic         grant_ack,
   output logic [W-1:0] grant_idx,
   output logic         grant_valid,
   output logic         timeout_pulse
);

   typedef enum logic {IDLE, GRANT} state_t;

   // Last hold count before a forced release. Unused when TIMEOUT == 0.
   localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t        state, state_nx;
   logic [W-1:0]  ptr, ptr_nx;
   logic [W-1:0]  idx_q, idx_nx;
   logic [CW-1:0] hold_cnt, hold_nx;
   logic          pulse_q, pulse_nx;

   // First set bit of r scanning from start upward. N == 2**W, so plain
   // W-bit addition gives the modulo-N wrap for free.
   function automatic logic [W-1:0] sel(input logic [W-1:0] start,
                                        input logic [N-1:0] r);
      logic [W-1:0] k;
      logic         found;
      sel   = start;
      found = 1'b0;
      for (int i = 0; i < N; i++) begin
         k = start + W'(i);
         if (!found && r[k]) begin
            sel   = k;
            found = 1'b1;
         end
      end
   endfunction

   // State register
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state    <= IDLE;
         ptr      <= '0;
         idx_q    <= '0;
         hold_cnt <= '0;
         pulse_q  <= 1'b0;
      end else begin
         state    <= state_nx;
         ptr      <= ptr_nx;
         idx_q    <= idx_nx;
         hold_cnt <= hold_nx;
         pulse_q  <= pulse_nx;
      end
   end

   // Next-state logic
   logic [W-1:0] after_idx;
   logic [N-1:0] served, req_m;
   logic         timed_out;

   always_comb begin
      state_nx  = state;
      ptr_nx    = ptr;
      idx_nx    = idx_q;
      hold_nx   = hold_cnt;
      pulse_nx  = 1'b0;
      after_idx = idx_q + 1'b1;
      served    = '0;
      served[idx_q] = 1'b1;
      // The requester just served is masked so it never re-wins on its own
      // release edge; it comes back through IDLE one cycle later.
      req_m     = req & ~served;
      timed_out = (TIMEOUT > 0) && !grant_ack && (hold_cnt == TO_LAST);

      unique case (state)
         IDLE: begin
            if (|req) begin
               idx_nx   = sel(ptr, req);
               hold_nx  = '0;
               state_nx = GRANT;
            end
         end
         GRANT: begin
            if (grant_ack || timed_out) begin
               // A timeout release is identical to an ack release apart from
               // the pulse; an ack in the last cycle wins and stays silent.
               ptr_nx   = after_idx;
               hold_nx  = '0;
               pulse_nx = timed_out;
               if (|req_m) idx_nx   = sel(after_idx, req_m);
               else        state_nx = IDLE;
            end else if ((TIMEOUT > 0) && (hold_cnt != '1)) begin
               hold_nx = hold_cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Outputs come straight from registers; nothing combinational from inputs.
   always_comb begin
      grant_idx     = idx_q;
      grant_valid   = (state == GRANT);
      timeout_pulse = pulse_q;
   end

endmodule

// File: tb/tb_rr_index_arbiter.sv
module tb_rr_index_arbiter;

   localparam int N  = 16;
   localparam int W  = 4;
   localparam int TO = 4;

   logic         CLK = 1'b0;
   logic         RESET = 1'b1;
   logic [N-1:0] req = '0;
   logic         grant_ack = 1'b0;
   logic [W-1:0] grant_idx;
   logic         grant_valid;
   logic         timeout_pulse;

   int checks = 0;
   int errors = 0;
   bit chk_en = 0;

   rr_index_arbiter #(.N(N), .W(W), .TIMEOUT(TO), .CW(8)) dut (
      .CLK          (CLK),
      .RESET        (RESET),
      .req          (req),
      .grant_ack    (grant_ack),
      .grant_idx    (grant_idx),
      .grant_valid  (grant_valid),
      .timeout_pulse(timeout_pulse)
   );

   always #5 CLK = ~CLK;

   // ---------------- behavioural model ----------------
   // Tracks who holds the grant, how many unacked cycles it has been held,
   // and where the round-robin search starts next.
   int m_idx   = 0;
   int m_ptr   = 0;
   int m_held  = 0;
   bit m_valid = 0;
   bit m_pulse = 0;

   function automatic int pick(input int start, input logic [N-1:0] r);
      for (int i = 0; i < N; i++) begin
         if (r[(start + i) % N]) return (start + i) % N;
      end
      return -1;
   endfunction

   always @(posedge CLK) begin
      logic [N-1:0] rest;
      bit           ack_rel, to_rel;
      if (RESET) begin
         m_idx = 0; m_ptr = 0; m_held = 0; m_valid = 0; m_pulse = 0;
      end else begin
         m_pulse = 0;
         if (!m_valid) begin
            if (req != 0) begin
               m_idx   = pick(m_ptr, req);
               m_valid = 1;
               m_held  = 0;
            end
         end else begin
            ack_rel = grant_ack;
            to_rel  = !grant_ack && (m_held + 1 == TO);
            if (ack_rel || to_rel) begin
               m_pulse = to_rel;
               m_ptr   = (m_idx + 1) % N;
               rest    = req;
               rest[m_idx] = 1'b0;
               m_held  = 0;
               if (rest != 0) m_idx = pick(m_ptr, rest);
               else           m_valid = 0;
            end else begin
               m_held++;
            end
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge CLK) begin
      if (chk_en) begin
         checks++;
         if (grant_valid !== m_valid) begin
            errors++;
            $display("FAIL cmp_valid t=%0t got %b exp %b", $time, grant_valid, m_valid);
         end
         checks++;
         if (grant_idx !== W'(m_idx)) begin
            errors++;
            $display("FAIL cmp_idx t=%0t got %0d exp %0d", $time, grant_idx, m_idx);
         end
         checks++;
         if (timeout_pulse !== m_pulse) begin
            errors++;
            $display("FAIL cmp_pulse t=%0t got %b exp %b", $time, timeout_pulse, m_pulse);
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic cyc(input logic [N-1:0] r, input logic a, input logic rs);
      @(negedge CLK);
      req = r; grant_ack = a; RESET = rs;
      @(posedge CLK);
      #1;
   endtask

   task automatic lit(input string nm, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d", nm, got, exp);
      end
   endtask

   task automatic lit3(input string nm, input int v, input int idx, input int tp);
      lit({nm, "_valid"}, int'(grant_valid), v);
      lit({nm, "_idx"}, int'(grant_idx), idx);
      lit({nm, "_pulse"}, int'(timeout_pulse), tp);
   endtask

   initial begin
      // reset and idle with no requests
      cyc('0, 0, 1);
      chk_en = 1;
      cyc('0, 0, 1);
      lit3("reset", 0, 0, 0);
      for (int i = 0; i < 5; i++) begin
         cyc('0, 0, 0);
         lit3("idle", 0, 0, 0);
      end

      // single request, hold 3 cycles, ack in the last-count cycle
      cyc(16'h0001, 0, 0);
      lit3("single_grant", 1, 0, 0);
      for (int i = 0; i < 3; i++) begin
         cyc('0, 0, 0);
         lit3("single_hold", 1, 0, 0);
      end
      cyc('0, 1, 0);
      lit3("single_release", 0, 0, 0);
      lit("model_ptr_after_0", m_ptr, 1);
      cyc(16'h0003, 0, 0);
      lit3("ptr_is_1", 1, 1, 0);
      cyc('0, 1, 0);
      lit("ptr_is_1_release", int'(grant_valid), 0);

      // back-to-back rotation with wrap 15 -> 0
      cyc('0, 0, 1);
      cyc(16'h8421, 0, 0);
      lit3("b2b_0", 1, 0, 0);
      cyc(16'h8421, 1, 0); lit3("b2b_5", 1, 5, 0);
      cyc(16'h8421, 1, 0); lit3("b2b_10", 1, 10, 0);
      cyc(16'h8421, 1, 0); lit3("b2b_15", 1, 15, 0);
      cyc(16'h8421, 1, 0); lit3("b2b_wrap0", 1, 0, 0);
      lit("model_idx_wrap", m_idx, 0);
      cyc('0, 1, 0);
      lit("b2b_done", int'(grant_valid), 0);

      // lone requester re-wins via IDLE
      cyc(16'h0008, 0, 0); lit3("lone_a", 1, 3, 0);
      cyc(16'h0008, 1, 0); lit3("lone_b", 0, 3, 0);
      cyc(16'h0008, 0, 0); lit3("lone_c", 1, 3, 0);
      cyc(16'h0008, 1, 0); lit3("lone_d", 0, 3, 0);
      cyc('0, 0, 0);

      // timeout after exactly TO held cycles
      cyc(16'h0040, 0, 0); lit3("to_hold0", 1, 6, 0);
      for (int i = 1; i < TO; i++) begin
         cyc(16'h0040, 0, 0);
         lit3("to_hold", 1, 6, 0);
      end
      cyc(16'h0040, 0, 0); lit3("to_fire", 0, 6, 1);
      lit("model_pulse", int'(m_pulse), 1);
      cyc(16'h0040, 0, 0); lit3("to_regrant", 1, 6, 0);
      cyc('0, 1, 0);

      // reset mid-grant
      cyc(16'h0200, 0, 0); lit3("mid_grant", 1, 9, 0);
      cyc(16'h0300, 0, 1); lit3("mid_reset", 0, 0, 0);
      cyc(16'h0300, 0, 0); lit3("post_reset", 1, 8, 0);

      // randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++) begin
         logic [N-1:0] r;
         int           mode;
         mode = $urandom_range(0, 5);
         case (mode)
            0:       r = '0;
            1:       r = N'(1) << $urandom_range(0, N - 1);
            2:       r = N'($urandom) & N'($urandom) & N'($urandom);
            default: r = N'($urandom);
         endcase
         cyc(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
      end

      @(negedge CLK);
      chk_en = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
